// File: rtl/bus_access_sequencer_pkg.sv
// Shared types and default widths for the CPU-to-pin-bus access sequencer.
// Imported by the sequencer and by any CPU-side logic that drives it.
package bus_access_sequencer_pkg;

    localparam int DEF_CPU_ADDRESS_WIDTH = 32;
    localparam int DEF_CPU_DATA_WIDTH    = 32;
    localparam int DEF_BUS_ADDRESS_WIDTH = 8;
    localparam int DEF_BUS_DATA_WIDTH    = 8;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BEAT = 2'b01,
        DONE = 2'b10
    } sequencer_state_t;

    // Number of bus beats for an access: 2**size, limited to the lanes a CPU word holds.
    function automatic int beat_count(input access_size_t size, input int max_beats);
        int n;
        n = 32'sd1 << size;
        if (n > max_beats) begin
            n = max_beats;
        end else begin
            n = n;
        end
        return n;
    endfunction

endpackage

// File: rtl/bus_access_sequencer_if.sv
// CPU request/response handshake plus narrow pin-bus signals of the access sequencer.
// 'slave' is the sequencer's view; 'master' is the CPU / pad-side environment's view.
interface bus_access_sequencer_if #(
    parameter int CPU_ADDRESS_WIDTH = 32,
    parameter int CPU_DATA_WIDTH    = 32,
    parameter int BUS_ADDRESS_WIDTH = 8,
    parameter int BUS_DATA_WIDTH    = 8
);
    logic                         request_valid;
    logic                         request_ready;
    logic                         request_write;
    logic [1:0]                   request_size;
    logic [CPU_ADDRESS_WIDTH-1:0] request_address;
    logic [CPU_DATA_WIDTH-1:0]    request_write_data;
    logic                         response_valid;
    logic                         response_error;
    logic [CPU_DATA_WIDTH-1:0]    response_read_data;
    logic                         busy;
    logic [BUS_ADDRESS_WIDTH-1:0] bus_address;
    logic                         bus_write_enable;
    logic [BUS_DATA_WIDTH-1:0]    bus_write_data;
    logic [BUS_DATA_WIDTH-1:0]    bus_read_data;

    modport slave (
        input  request_valid, request_write, request_size, request_address,
               request_write_data, bus_read_data,
        output request_ready, response_valid, response_error, response_read_data,
               busy, bus_address, bus_write_enable, bus_write_data
    );

    modport master (
        output request_valid, request_write, request_size, request_address,
               request_write_data, bus_read_data,
        input  request_ready, response_valid, response_error, response_read_data,
               busy, bus_address, bus_write_enable, bus_write_data
    );
endinterface

// File: rtl/bus_access_sequencer.sv
// Splits byte/half/word CPU accesses into 8-bit pin-bus beats and assembles load data
// little-endian; one response pulse per accepted request, all outputs registered.
module bus_access_sequencer
    import bus_access_sequencer_pkg::*;
#(
    parameter int CPU_ADDRESS_WIDTH = DEF_CPU_ADDRESS_WIDTH,
    parameter int CPU_DATA_WIDTH    = DEF_CPU_DATA_WIDTH,
    parameter int BUS_ADDRESS_WIDTH = DEF_BUS_ADDRESS_WIDTH,
    parameter int BUS_DATA_WIDTH    = DEF_BUS_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    bus_access_sequencer_if.slave io
);

    localparam int MAX_BEATS = CPU_DATA_WIDTH / BUS_DATA_WIDTH;
    localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    sequencer_state_t             state_q, state_d;
    logic [BEAT_W-1:0]            beat_q, beat_d;
    logic [BEAT_W-1:0]            last_q, last_d;
    logic                         write_q, write_d;
    logic [CPU_DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [CPU_DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [BUS_ADDRESS_WIDTH-1:0] bus_address_q, bus_address_d;
    logic                         bus_we_q, bus_we_d;
    logic [BUS_DATA_WIDTH-1:0]    bus_wdata_q, bus_wdata_d;
    logic                         response_valid_q, response_valid_d;
    logic                         response_error_q, response_error_d;
    logic                         request_ready_q, request_ready_d;
    logic                         busy_q, busy_d;
    access_size_t                 size_s;

    assign size_s = access_size_t'(io.request_size);

    // Next-state and next-output logic; bus outputs for beat k are prepared one edge early.
    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
        last_d           = last_q;
        write_d          = write_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        bus_address_d    = bus_address_q;
        bus_we_d         = 1'b0;
        bus_wdata_d      = bus_wdata_q;
        response_valid_d = 1'b0;
        response_error_d = 1'b0;
        request_ready_d  = 1'b0;
        busy_d           = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.request_valid) begin
                    write_d = io.request_write;
                    wdata_d = io.request_write_data;
                    rdata_d = '0;
                    beat_d  = '0;
                    busy_d  = 1'b1;
                    if (size_s == ILLEGAL) begin
                        state_d          = DONE;
                        response_valid_d = 1'b1;
                        response_error_d = 1'b1;
                    end else begin
                        state_d       = BEAT;
                        last_d        = BEAT_W'(beat_count(size_s, MAX_BEATS) - 1);
                        bus_address_d = io.request_address[BUS_ADDRESS_WIDTH-1:0];
                        bus_we_d      = io.request_write;
                        if (io.request_write) begin
                            bus_wdata_d = io.request_write_data[BUS_DATA_WIDTH-1:0];
                        end else begin
                            bus_wdata_d = bus_wdata_q;
                        end
                    end
                end else begin
                    request_ready_d = 1'b1;
                end
            end
            BEAT: begin
                busy_d = 1'b1;
                if (!write_q) begin
                    rdata_d[int'(beat_q)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = io.bus_read_data;
                end else begin
                    rdata_d = rdata_q;
                end
                if (beat_q == last_q) begin
                    state_d          = DONE;
                    response_valid_d = 1'b1;
                end else begin
                    beat_d        = beat_q + BEAT_W'(1);
                    bus_address_d = bus_address_q + BUS_ADDRESS_WIDTH'(1);
                    bus_we_d      = write_q;
                    if (write_q) begin
                        bus_wdata_d = wdata_q[int'(beat_d)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                    end else begin
                        bus_wdata_d = bus_wdata_q;
                    end
                end
            end
            DONE: begin
                state_d         = IDLE;
                request_ready_d = 1'b1;
            end
            default: begin
                state_d         = IDLE;
                request_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            beat_q           <= '0;
            last_q           <= '0;
            write_q          <= 1'b0;
            wdata_q          <= '0;
            rdata_q          <= '0;
            bus_address_q    <= '0;
            bus_we_q         <= 1'b0;
            bus_wdata_q      <= '0;
            response_valid_q <= 1'b0;
            response_error_q <= 1'b0;
            request_ready_q  <= 1'b1;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            beat_q           <= beat_d;
            last_q           <= last_d;
            write_q          <= write_d;
            wdata_q          <= wdata_d;
            rdata_q          <= rdata_d;
            bus_address_q    <= bus_address_d;
            bus_we_q         <= bus_we_d;
            bus_wdata_q      <= bus_wdata_d;
            response_valid_q <= response_valid_d;
            response_error_q <= response_error_d;
            request_ready_q  <= request_ready_d;
            busy_q           <= busy_d;
        end
    end

    assign io.request_ready      = request_ready_q;
    assign io.response_valid     = response_valid_q;
    assign io.response_error     = response_error_q;
    assign io.response_read_data = rdata_q;
    assign io.busy               = busy_q;
    assign io.bus_address        = bus_address_q;
    assign io.bus_write_enable   = bus_we_q;
    assign io.bus_write_data     = bus_wdata_q;

endmodule

// File: tb/tb_bus_access_sequencer.sv
// Randomized self-checking bench for bus_access_sequencer against a per-access
// reference model (beat list, response timing, little-endian load assembly).
module tb_bus_access_sequencer;
    import bus_access_sequencer_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] last_addr;
    logic [7:0] last_wdata;

    always #5 clock = ~clock;

    bus_access_sequencer_if io ();

    bus_access_sequencer dut (
        .clock (clock),
        .reset (reset),
        .io    (io.slave)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_garbage(input logic keep_valid);
        io.request_valid      = keep_valid;
        io.request_write      = 1'($urandom);
        io.request_size       = 2'($urandom);
        io.request_address    = 32'($urandom);
        io.request_write_data = 32'($urandom);
    endtask

    // One full access from accept to the cycle after its response; called at a negedge.
    task automatic run_access(input logic w, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rb, input logic hold_valid);
        int n;
        int wait_cnt;
        logic [31:0] exp_rd;
        logic [7:0]  exp_a;
        n = (size == 2'b11) ? 0 : (1 << size);
        wait_cnt = 0;
        while (io.request_ready !== 1'b1 && wait_cnt < 20) begin
            @(negedge clock);
            wait_cnt++;
        end
        checks++;
        if (io.request_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_timeout: request_ready=%b required 1", io.request_ready);
        end
        io.request_valid      = 1'b1;
        io.request_write      = w;
        io.request_size       = size;
        io.request_address    = addr;
        io.request_write_data = wd;
        @(posedge clock);
        @(negedge clock);
        drive_garbage(hold_valid);
        exp_rd = 32'h0;
        for (int k = 0; k < n; k++) begin
            exp_a = addr[7:0] + 8'(k);
            io.bus_read_data = rb[8*k +: 8];
            if (w) last_wdata = wd[8*k +: 8];
            if (!w) exp_rd[8*k +: 8] = rb[8*k +: 8];
            last_addr = exp_a;
            checks++;
            if (io.bus_address !== exp_a) begin
                failures++;
                $display("FAIL beat_addr k=%0d: got %h required %h", k, io.bus_address, exp_a);
            end
            checks++;
            if (io.bus_write_enable !== w) begin
                failures++;
                $display("FAIL beat_we k=%0d: got %b required %b", k, io.bus_write_enable, w);
            end
            checks++;
            if (io.bus_write_data !== last_wdata) begin
                failures++;
                $display("FAIL beat_wdata k=%0d: got %h required %h", k, io.bus_write_data, last_wdata);
            end
            checks++;
            if (io.busy !== 1'b1 || io.response_valid !== 1'b0 || io.request_ready !== 1'b0) begin
                failures++;
                $display("FAIL beat_status k=%0d: busy=%b rv=%b ready=%b required 1,0,0",
                         k, io.busy, io.response_valid, io.request_ready);
            end
            @(negedge clock);
            drive_garbage(hold_valid);
            io.bus_read_data = 8'($urandom);
        end
        if (w) exp_rd = 32'h0;
        checks++;
        if (io.response_valid !== 1'b1 || io.response_error !== (size == 2'b11)) begin
            failures++;
            $display("FAIL done_resp: valid=%b error=%b required 1,%b",
                     io.response_valid, io.response_error, (size == 2'b11));
        end
        checks++;
        if (io.response_read_data !== exp_rd) begin
            failures++;
            $display("FAIL done_rdata: got %h required %h", io.response_read_data, exp_rd);
        end
        checks++;
        if (io.bus_write_enable !== 1'b0 || io.busy !== 1'b1 || io.request_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_status: we=%b busy=%b ready=%b required 0,1,0",
                     io.bus_write_enable, io.busy, io.request_ready);
        end
        checks++;
        if (io.bus_address !== last_addr || io.bus_write_data !== last_wdata) begin
            failures++;
            $display("FAIL done_hold: addr=%h wdata=%h required %h,%h",
                     io.bus_address, io.bus_write_data, last_addr, last_wdata);
        end
        @(negedge clock);
        checks++;
        if (io.request_ready !== 1'b1 || io.response_valid !== 1'b0 || io.busy !== 1'b0 ||
            io.bus_write_enable !== 1'b0) begin
            failures++;
            $display("FAIL after_done: ready=%b rv=%b busy=%b we=%b required 1,0,0,0",
                     io.request_ready, io.response_valid, io.busy, io.bus_write_enable);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_garbage(1'b0);
        io.bus_read_data = 8'h00;
        #12;
        checks++;
        if (io.request_ready !== 1'b1 || io.response_valid !== 1'b0 || io.response_error !== 1'b0 ||
            io.busy !== 1'b0 || io.bus_write_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b rv=%b err=%b busy=%b we=%b required 1,0,0,0,0",
                     io.request_ready, io.response_valid, io.response_error, io.busy, io.bus_write_enable);
        end
        checks++;
        if (io.bus_address !== 8'h00 || io.bus_write_data !== 8'h00 || io.response_read_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h required 0",
                     io.bus_address, io.bus_write_data, io.response_read_data);
        end
        @(negedge clock);
        reset = 1'b0;
        last_addr  = 8'h00;
        last_wdata = 8'h00;
    endtask

    task automatic test_word_store_wrap();
        run_access(1'b1, 2'b10, 32'h000000FE, 32'h11223344, 32'h0, 1'b0);
    endtask

    task automatic test_byte_load();
        run_access(1'b0, 2'b00, 32'h00000010, 32'h0, 32'h000000A5, 1'b0);
    endtask

    task automatic test_half_load();
        run_access(1'b0, 2'b01, 32'h00000020, 32'h0, 32'h0000ABCD, 1'b0);
    endtask

    task automatic test_illegal();
        run_access(1'b1, 2'b11, 32'h00000033, 32'hFFFFFFFF, 32'h0, 1'b0);
        run_access(1'b0, 2'b11, 32'h00000044, 32'h0, 32'hFFFFFFFF, 1'b0);
    endtask

    task automatic test_reset_mid();
        io.request_valid      = 1'b1;
        io.request_write      = 1'b1;
        io.request_size       = 2'b10;
        io.request_address    = 32'h00000040;
        io.request_write_data = 32'hDEADBEEF;
        @(posedge clock);
        @(negedge clock);
        drive_garbage(1'b0);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (io.bus_write_enable !== 1'b1 || io.bus_address !== 8'h42 || io.bus_write_data !== 8'hAD) begin
            failures++;
            $display("FAIL mid_beat2: we=%b addr=%h wdata=%h required 1,42,ad",
                     io.bus_write_enable, io.bus_address, io.bus_write_data);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (io.bus_write_enable !== 1'b0 || io.request_ready !== 1'b1 || io.busy !== 1'b0 ||
            io.response_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: we=%b ready=%b busy=%b rv=%b required 0,1,0,0",
                     io.bus_write_enable, io.request_ready, io.busy, io.response_valid);
        end
        @(negedge clock);
        reset = 1'b0;
        last_addr  = 8'h00;
        last_wdata = 8'h00;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (io.response_valid !== 1'b0 || io.bus_write_enable !== 1'b0) begin
                failures++;
                $display("FAIL mid_no_resp cycle=%0d: rv=%b we=%b required 0,0",
                         i, io.response_valid, io.bus_write_enable);
            end
            @(negedge clock);
        end
        run_access(1'b0, 2'b00, 32'h00000077, 32'h0, 32'h0000005A, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_access(1'($urandom), 2'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 1'b1);
        end
        io.request_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_access(1'($urandom), 2'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_word_store_wrap();
        test_byte_load();
        test_half_load();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
